// File: rtl/cmp_stat_unit_if.sv
// Sample/statistics bundle between a magnitude-comparator front end and cmp_stat_unit.
// The slave side is the statistics unit; the master side drives samples and reads counts.
interface cmp_stat_unit_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             less;
  logic             greater;
  logic             equal;
  logic             clr;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic             run_hit;
  logic [CNT_W-1:0] run_cnt;
  logic             flag_err;
  logic [1:0]       state;

  modport master (
    output in_valid, less, greater, equal, clr,
    input  lt_cnt, gt_cnt, eq_cnt, run_hit, run_cnt, flag_err, state
  );

  modport slave (
    input  in_valid, less, greater, equal, clr,
    output lt_cnt, gt_cnt, eq_cnt, run_hit, run_cnt, flag_err, state
  );
endinterface

// File: rtl/cmp_stat_unit.sv
// Statistics on comparator results: saturating per-relation counts, detection of
// runs of RUN_LEN consecutive equal samples, and a sticky error for non-one-hot flags.
module cmp_stat_unit #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RUN_LEN = 3
) (
  input  logic           clk,
  input  logic           rst,
  cmp_stat_unit_if.slave bus
);

  localparam int unsigned LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t           st;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] lt_cnt_q;
  logic [CNT_W-1:0] gt_cnt_q;
  logic [CNT_W-1:0] eq_cnt_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic             run_hit_q;
  logic             flag_err_q;

  logic [2:0]       flags;
  logic             legal;
  logic             eq_smp;
  logic [LEN_W-1:0] len_inc;

  // Sample decode: legal means exactly one relation flag is set.
  always_comb begin
    flags   = {bus.less, bus.greater, bus.equal};
    legal   = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    eq_smp  = bus.in_valid && legal && bus.equal;
    len_inc = len + LEN_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      len        <= '0;
      lt_cnt_q   <= '0;
      gt_cnt_q   <= '0;
      eq_cnt_q   <= '0;
      run_cnt_q  <= '0;
      run_hit_q  <= 1'b0;
      flag_err_q <= 1'b0;
    end else if (bus.clr) begin
      // Clear wins over any sample presented in the same cycle.
      st         <= IDLE;
      len        <= '0;
      lt_cnt_q   <= '0;
      gt_cnt_q   <= '0;
      eq_cnt_q   <= '0;
      run_cnt_q  <= '0;
      run_hit_q  <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      run_hit_q <= 1'b0;

      if (bus.in_valid) begin
        if (legal) begin
          if (bus.less && (lt_cnt_q != '1))    lt_cnt_q <= lt_cnt_q + CNT_W'(1);
          if (bus.greater && (gt_cnt_q != '1)) gt_cnt_q <= gt_cnt_q + CNT_W'(1);
          if (bus.equal && (eq_cnt_q != '1))   eq_cnt_q <= eq_cnt_q + CNT_W'(1);
        end else begin
          flag_err_q <= 1'b1;
        end
      end

      // HIT decides its successor exactly like IDLE, so runs never overlap.
      case (st)
        IDLE, HIT: begin
          if (eq_smp) begin
            st  <= RUN;
            len <= LEN_W'(1);
          end else begin
            st  <= IDLE;
            len <= '0;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            if (eq_smp) begin
              if (32'(len_inc) == RUN_LEN) begin
                st        <= HIT;
                len       <= '0;
                run_hit_q <= 1'b1;
                if (run_cnt_q != '1) run_cnt_q <= run_cnt_q + CNT_W'(1);
              end else begin
                len <= len_inc;
              end
            end else begin
              st  <= IDLE;
              len <= '0;
            end
          end
        end
        default: begin
          st  <= IDLE;
          len <= '0;
        end
      endcase
    end
  end

  assign bus.lt_cnt   = lt_cnt_q;
  assign bus.gt_cnt   = gt_cnt_q;
  assign bus.eq_cnt   = eq_cnt_q;
  assign bus.run_cnt  = run_cnt_q;
  assign bus.run_hit  = run_hit_q;
  assign bus.flag_err = flag_err_q;
  assign bus.state    = st;

endmodule

// File: tb/tb_cmp_stat_unit.sv
// Directed self-checking bench for cmp_stat_unit (CNT_W=4, RUN_LEN=3).
module tb_cmp_stat_unit;

  localparam int unsigned CNT_W = 4;
  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   hits;

  cmp_stat_unit_if #(.CNT_W(CNT_W)) bus ();

  cmp_stat_unit #(.CNT_W(CNT_W), .RUN_LEN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [2:0] f);
    @(negedge clk);
    bus.in_valid = 1'b1;
    {bus.less, bus.greater, bus.equal} = f;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    {bus.less, bus.greater, bus.equal} = 3'b000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr(input logic v, input logic [2:0] f);
    @(negedge clk);
    bus.clr      = 1'b1;
    bus.in_valid = v;
    {bus.less, bus.greater, bus.equal} = f;
    @(posedge clk);
    #1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    {bus.less, bus.greater, bus.equal} = 3'b000;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_lt"},    32'(bus.lt_cnt),   0);
    check({tag, "_gt"},    32'(bus.gt_cnt),   0);
    check({tag, "_eq"},    32'(bus.eq_cnt),   0);
    check({tag, "_run"},   32'(bus.run_cnt),  0);
    check({tag, "_hit"},   32'(bus.run_hit),  0);
    check({tag, "_err"},   32'(bus.flag_err), 0);
    check({tag, "_state"}, 32'(bus.state),    0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.less = 1'b0;
    bus.greater = 1'b0;
    bus.equal = 1'b0;
    bus.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic run: 01, 01, 10 then back to idle
    smp(EQ); check("s1_st1", 32'(bus.state), 1);
    smp(EQ); check("s1_st2", 32'(bus.state), 1);
    check("s1_hit_early", 32'(bus.run_hit), 0);
    smp(EQ); check("s1_st3", 32'(bus.state), 2);
    check("s1_hit", 32'(bus.run_hit), 1);
    check("s1_eq", 32'(bus.eq_cnt), 3);
    check("s1_run", 32'(bus.run_cnt), 1);
    idle(1);
    check("s1_hit_drop", 32'(bus.run_hit), 0);
    check("s1_st_idle", 32'(bus.state), 0);
    do_clr(1'b0, 3'b000);
    check_zero("clr1");

    // Broken run: EQ EQ LT EQ EQ EQ -> single hit after the 6th sample
    hits = 0;
    smp(EQ); hits += int'(bus.run_hit);
    smp(EQ); hits += int'(bus.run_hit);
    smp(LT); hits += int'(bus.run_hit);
    check("s2_st_after_lt", 32'(bus.state), 0);
    smp(EQ); hits += int'(bus.run_hit);
    smp(EQ); hits += int'(bus.run_hit);
    check("s2_no_hit_yet", 32'(hits), 0);
    smp(EQ);
    check("s2_hit6", 32'(bus.run_hit), 1);
    check("s2_lt", 32'(bus.lt_cnt), 1);
    check("s2_eq", 32'(bus.eq_cnt), 5);
    check("s2_run", 32'(bus.run_cnt), 1);
    do_clr(1'b0, 3'b000);

    // Six equals -> hits after samples 3 and 6
    for (int i = 1; i <= 6; i++) begin
      smp(EQ);
      check($sformatf("s3_hit%0d", i), 32'(bus.run_hit), (i == 3 || i == 6) ? 1 : 0);
    end
    check("s3_run", 32'(bus.run_cnt), 2);
    check("s3_eq", 32'(bus.eq_cnt), 6);
    do_clr(1'b0, 3'b000);

    // Illegal flags in RUN -> error, idle, no count change, sticky until clr
    smp(EQ); smp(EQ);
    check("s4_st_run", 32'(bus.state), 1);
    smp(3'b011);
    check("s4_err", 32'(bus.flag_err), 1);
    check("s4_st", 32'(bus.state), 0);
    check("s4_eq", 32'(bus.eq_cnt), 2);
    check("s4_gt", 32'(bus.gt_cnt), 0);
    check("s4_lt", 32'(bus.lt_cnt), 0);
    idle(2);
    smp(LT);
    check("s4_err_sticky", 32'(bus.flag_err), 1);
    check("s4_lt_after", 32'(bus.lt_cnt), 1);
    smp(EQ); smp(EQ);
    check("s4_len_reset", 32'(bus.state), 1);
    check("s4_no_hit", 32'(bus.run_hit), 0);
    do_clr(1'b0, 3'b000);
    check("s4_err_clr", 32'(bus.flag_err), 0);

    // in_valid=0 holds RUN and its length
    smp(EQ); idle(2);
    check("s5_hold", 32'(bus.state), 1);
    smp(EQ); idle(3);
    check("s5_hold2", 32'(bus.state), 1);
    smp(EQ);
    check("s5_hit", 32'(bus.run_hit), 1);
    do_clr(1'b0, 3'b000);

    // Saturation at 15, then clr with a simultaneous sample
    for (int i = 0; i < 20; i++) smp(GT);
    check("s6_gt_sat", 32'(bus.gt_cnt), 15);
    do_clr(1'b1, GT);
    check_zero("s6_clr");

    // Async reset mid-run with len=2
    smp(EQ); smp(EQ);
    @(negedge clk);
    #1;
    check("s7_pre_state", 32'(bus.state), 1);
    rst = 1'b1;
    #1;
    check_zero("s7_rst");
    rst = 1'b0;
    hits = 0;
    smp(EQ); hits += int'(bus.run_hit);
    check("s7_st1", 32'(bus.state), 1);
    smp(EQ); hits += int'(bus.run_hit);
    smp(EQ); hits += int'(bus.run_hit);
    check("s7_hits", 32'(hits), 1);
    check("s7_run", 32'(bus.run_cnt), 1);
    check("s7_eq", 32'(bus.eq_cnt), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmp_stat_unit.md
CMP_STAT_UNIT -- requirements
Module: cmp_stat_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, which sets the width of each event counter.
REQ-002 The block SHALL have parameter RUN_LEN, default 3, which sets how many consecutive equal samples make a run; legal range is 2..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the less/greater/equal flags are a sample this cycle.
REQ-006 The block SHALL have ports less, greater, equal, input, 1 bit each: result flags from the upstream 4-bit magnitude comparator.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of all statistics.
REQ-008 The block SHALL have ports lt_cnt, gt_cnt, eq_cnt, output, CNT_W each: saturating sample counts per relation.
REQ-009 The block SHALL have port run_hit, output, 1 bit: a one-cycle pulse when a run of RUN_LEN consecutive equal samples completes.
REQ-010 The block SHALL have port run_cnt, output, CNT_W: saturating count of completed runs.
REQ-011 The block SHALL have port flag_err, output, 1 bit: sticky, set when a sample's flags are not exactly one-hot.
REQ-012 The block SHALL have port state, output, 2 bits: the current FSM state encoding.

Function
REQ-013 A cycle with in_valid=0 SHALL leave all counters, the FSM and flag_err unchanged, and run_hit SHALL be 0 on the next cycle.
REQ-014 A legal sample (exactly one flag set, in_valid=1) SHALL increment the matching counter at the next rising edge, with latency 1 cycle.
REQ-015 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-016 An illegal sample (flags 000, 011, 101, 110 or 111 with in_valid=1) SHALL increment no counter, set flag_err=1, and force the FSM to IDLE with the equal-run length at 0.
REQ-017 The FSM SHALL have states IDLE=2'b00, RUN=2'b01 and HIT=2'b10; 2'b11 is unreachable and SHALL recover to IDLE on the next edge.
REQ-018 The FSM SHALL track an internal 4-bit run length len.
REQ-019 From IDLE, a legal equal sample SHALL move the FSM to RUN with len=1; any other input leaves it in IDLE.
REQ-020 In RUN:
- legal equal with len+1<RUN_LEN: stay in RUN, len increments;
- legal equal with len+1==RUN_LEN: go to HIT, len=0;
- legal less/greater or illegal sample: go to IDLE, len=0;
- in_valid=0: hold.
REQ-021 HIT SHALL last exactly one cycle, and run_hit SHALL equal 1 only while state==HIT.
REQ-022 run_cnt SHALL increment on entry to HIT.
REQ-023 On the HIT cycle, the next state SHALL be decided as from IDLE: a legal equal sample presented during HIT goes to RUN with len=1, so runs never overlap.
REQ-024 clr=1 SHALL zero all counters, len and flag_err, and force IDLE at the next edge; clr SHALL take priority over a simultaneous in_valid sample, and that sample is discarded.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 On rst=1, the block SHALL immediately and asynchronously set lt_cnt, gt_cnt, eq_cnt and run_cnt to 0, run_hit=0, flag_err=0, state=IDLE and len=0.
REQ-027 Reset asserted mid-run or during HIT SHALL abort the run with no run_hit pulse and no run_cnt increment.
REQ-028 After rst deasserts, the first rising edge SHALL accept samples normally.

Verification
REQ-029 The bench SHALL cover: reset, then legal samples equal, equal, equal (RUN_LEN=3) -> state goes 01, 01, 10; run_hit=1 for one cycle; eq_cnt=3; run_cnt=1.
REQ-030 The bench SHALL cover: samples equal, equal, less, equal, equal, equal -> exactly one run_hit, after the 6th sample; lt_cnt=1; eq_cnt=5.
REQ-031 The bench SHALL cover: six consecutive equal samples -> two run_hit pulses, 3 cycles apart; run_cnt=2.
REQ-032 The bench SHALL cover: sample with flags 011 during RUN -> flag_err=1 and IDLE; no counter changes; flag_err stays 1 until clr.
REQ-033 The bench SHALL cover: CNT_W=4 with 20 greater samples -> gt_cnt holds 15 without wrapping; clr together with in_valid -> all counts 0 and the sample ignored.
REQ-034 The bench SHALL cover: rst pulsed mid-cycle while len=2 -> outputs 0 immediately; the next three equal samples produce one run_hit.
